// File: rtl/adder_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : adder_result_fifo
// Description : Credit-based result buffer that sits after a fixed-latency,
//               registered 64-bit adder pipeline. A valid delay line follows
//               each accepted operand pair through the pipeline. The matching
//               {cout,sum} is captured into a DEPTH-entry FIFO and drained
//               through a valid/ready port. Upstream issue is throttled by
//               credits, so a result can never arrive at a full FIFO.
// Options     : ADDRES_STALL_CNT_EN - adds a saturating 16-bit stall_cnt
//               output that counts cycles with issue_valid=1, issue_ready=0.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_result_fifo #(
    parameter int WIDTH   = 64,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic [WIDTH-1:0]       res_sum,
    input  logic                   res_cout,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_sum,
    output logic                   out_cout,
`ifdef ADDRES_STALL_CNT_EN
    output logic [15:0]            stall_cnt,
`endif
    output logic [$clog2(DEPTH):0] count
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // Pointer width, and occupancy/credit width (one extra bit to hold DEPTH).
    localparam int              c_AW    = $clog2(DEPTH);
    localparam int              c_CW    = c_AW + 1;
    localparam logic [c_CW-1:0] c_DEPTH = c_CW'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    // One bit per pipeline stage: bit k set means the operand pair accepted
    // k+1 cycles ago is still travelling through the adder.
    logic [LATENCY-1:0] r_vld_sr;

    // FIFO storage holds {cout, sum}. It is deliberately not reset; the
    // pointers and count alone decide which entries are meaningful.
    logic [WIDTH:0]     r_mem [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CW-1:0]    r_count;

    // Credits consumed: results issued but not yet popped, whether they are
    // still in the pipeline or already stored. Ranges 0..DEPTH.
    logic [c_CW-1:0]    r_used;

    // ------------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------------
    logic               w_accept;
    logic               w_write;
    logic               w_pop;
    logic [WIDTH:0]     w_head;

    // Credit check looks only at a register, so issue_ready has no
    // combinational path from any input.
    assign issue_ready = (r_used < c_DEPTH);
    assign w_accept    = issue_valid & issue_ready;

    // The oldest tap lines up with the cycle in which res_* carries the result.
    assign w_write     = r_vld_sr[LATENCY-1];

    assign out_valid   = (r_count != '0);
    assign w_pop       = out_valid & out_ready;

    // Head read is combinational; a value written this cycle only becomes
    // visible once count has been updated, so there is no write-to-read bypass.
    assign w_head      = r_mem[r_rd_ptr];
    assign out_sum     = out_valid ? w_head[WIDTH-1:0] : '0;
    assign out_cout    = out_valid & w_head[WIDTH];

    assign count       = r_count;

    // ------------------------------------------------------------------------
    // In-flight delay line
    // ------------------------------------------------------------------------
    generate
        if (LATENCY == 1) begin : g_vld_sr_single
            // Single-stage pipeline: the tap is just the registered accept.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= w_accept;
                end
            end
        end else begin : g_vld_sr_multi
            // Shift every cycle; a new accept enters at bit 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld_sr <= '0;
                end else begin
                    r_vld_sr <= {r_vld_sr[LATENCY-2:0], w_accept};
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------------
    // Capture the emerging adder result. Credits guarantee a free slot, so
    // the write is unconditional on occupancy.
    always_ff @(posedge clk) begin
        if (w_write) begin
            r_mem[r_wr_ptr] <= {res_cout, res_sum};
        end
    end

    // Write pointer advances on each captured result, wrapping modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
        end else if (w_write) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
        end
    end

    // Read pointer advances on each pop, wrapping modulo DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
        end
    end

    // Occupancy: a write and pop in the same cycle cancel out, even at count=1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            unique case ({w_write, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Credit accounting
    // ------------------------------------------------------------------------
    // A credit is taken on accept and returned on pop; the returned credit
    // shows up on issue_ready one cycle after the pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used <= '0;
        end else begin
            unique case ({w_accept, w_pop})
                2'b10:   r_used <= r_used + c_CW'(1);
                2'b01:   r_used <= r_used - c_CW'(1);
                default: r_used <= r_used;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Optional stall statistics
    // ------------------------------------------------------------------------
`ifdef ADDRES_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall   = issue_valid & ~issue_ready;
    assign stall_cnt = r_stall_cnt;

    // Count upstream cycles refused for lack of credit, saturating at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_adder_result_fifo
// Description : Directed self-checking bench for adder_result_fifo with
//               WIDTH=64, LATENCY=4, DEPTH=4. The adder is modelled as a
//               4-stage delay of a+b+cin; a scoreboard queue holds expected
//               {cout,sum} values in issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_result_fifo;

    localparam int c_W   = 64;
    localparam int c_LAT = 4;
    localparam int c_DEP = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic [c_W-1:0]   res_sum;
    logic             res_cout;
    logic             out_valid;
    logic             out_ready;
    logic [c_W-1:0]   out_sum;
    logic             out_cout;
    logic [2:0]       count;
`ifdef ADDRES_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    // Operands presented to the modelled adder.
    logic [c_W-1:0]   a;
    logic [c_W-1:0]   b;
    logic             cin;

    logic [c_W:0]     pipe [c_LAT];
    logic [c_W:0]     exp_q [$];

    int               checks;
    int               errors;
    int               pops;

    always #5 clk = ~clk;

    adder_result_fifo #(
        .WIDTH   (c_W),
        .LATENCY (c_LAT),
        .DEPTH   (c_DEP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .res_sum     (res_sum),
        .res_cout    (res_cout),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_cout    (out_cout),
`ifdef ADDRES_STALL_CNT_EN
        .stall_cnt   (stall_cnt),
`endif
        .count       (count)
    );

    // Unreset adder model: always computes, so stale results keep flowing.
    always @(posedge clk) begin
        pipe[0] <= {1'b0, a} + {1'b0, b} + 65'(cin);
        for (int i = 1; i < c_LAT; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end
    assign res_sum  = pipe[c_LAT-1][c_W-1:0];
    assign res_cout = pipe[c_LAT-1][c_W];

    initial begin
        #100000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: record accept/pop decisions on the settled inputs,
    // then move to 1 ns after the next rising edge.
    task automatic cyc();
        logic [c_W:0] e;
        if (issue_valid && issue_ready) begin
            exp_q.push_back({1'b0, a} + {1'b0, b} + 65'(cin));
        end
        if (out_valid && out_ready) begin
            check("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("pop_data", {63'd0, out_cout, out_sum}, {63'd0, e});
            end
            pops++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n           = 0;
        issue_valid = 1'b0;
        out_ready   = 1'b1;
        while (exp_q.size() != 0 && n < max_cycles) begin
            cyc();
            n++;
        end
        check("drain_empty", 128'(exp_q.size()), 128'd0);
        check("drain_count", 128'(count), 128'd0);
        check("drain_valid", 128'(out_valid), 128'd0);
        check("drain_sum0", 128'(out_sum), 128'd0);
    endtask

    initial begin
        int  k;
        int  g;
        int  p0;
        bit  acc;

        checks      = 0;
        errors      = 0;
        pops        = 0;
        rst         = 1'b1;
        issue_valid = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        cin         = 1'b0;

        // ---- 1. Reset values, then asynchronous reset mid-cycle ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_out_sum", 128'(out_sum), 128'd0);
        check("rst_count", 128'(count), 128'd0);
        check("rst_issue_ready", 128'(issue_ready), 128'd1);
        rst = 1'b0;
        cyc();
        issue_valid = 1'b1; a = 64'd3; b = 64'd2;
        cyc();
        issue_valid = 1'b0;
        repeat (5) cyc();
        check("pre_arst_count", 128'(count), 128'd1);
        check("pre_arst_valid", 128'(out_valid), 128'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'd0);
        check("arst_out_sum", 128'(out_sum), 128'd0);
        check("arst_count", 128'(count), 128'd0);
        check("arst_issue_ready", 128'(issue_ready), 128'd1);
        exp_q.delete();
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // ---- 2. Single op: 3+2 visible in cycle 5 only ----
        out_ready = 1'b1;
        issue_valid = 1'b1; a = 64'd3; b = 64'd2;
        cyc();
        issue_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("single_valid", 128'(out_valid), 128'(c == 5));
            if (c == 5) begin
                check("single_sum", 128'(out_sum), 128'd5);
                check("single_cout", 128'(out_cout), 128'd0);
            end
            cyc();
        end

        // ---- 3. Backpressure with continuous issue ----
        out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            check("bp_issue_ready", 128'(issue_ready), 128'(c < 4));
            check("bp_count", 128'(count), 128'((c <= 4) ? 0 : c - 4));
            issue_valid = 1'b1; a = 64'(100 + c); b = '0;
            cyc();
        end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("bp_pop_count", 128'(count), 128'd3);
        check("bp_pop_ready", 128'(issue_ready), 128'd1);
        cyc();
        check("bp_reissue_ready", 128'(issue_ready), 128'd0);
        drain(40);

        // ---- 4. Wrap and ordering, carry-in and carry-out ----
        p0 = pops;
        out_ready = 1'b1;
        k = 1;
        g = 0;
        while (k <= 10 && g < 200) begin
            issue_valid = 1'b1; a = 64'(k); b = '0;
            acc = issue_ready;
            cyc();
            if (acc) k++;
            g++;
        end
        drain(40);
        check("order_pops", 128'(pops - p0), 128'd10);
        p0 = pops;
        issue_valid = 1'b1; a = 64'd5; b = 64'd6; cin = 1'b1;
        cyc();
        cin = 1'b0; a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'd1;
        cyc();
        issue_valid = 1'b0;
        drain(40);
        check("carry_pops", 128'(pops - p0), 128'd2);

        // ---- 5a. Write and pop together at count=2 ----
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            issue_valid = 1'b1; a = 64'(21 + c); b = '0;
            cyc();
        end
        issue_valid = 1'b0;
        repeat (3) cyc();
        check("simul_count_pre", 128'(count), 128'd2);
        check("simul_head_pre", 128'(out_sum), 128'd21);
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        check("simul_count_post", 128'(count), 128'd2);
        check("simul_head_post", 128'(out_sum), 128'd22);
        drain(40);

        // ---- 5b. Pop and issue together with all credits used ----
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            issue_valid = 1'b1; a = 64'(41 + c); b = '0;
            cyc();
        end
        issue_valid = 1'b0;
        repeat (4) cyc();
        check("full_count", 128'(count), 128'd4);
        check("full_ready", 128'(issue_ready), 128'd0);
        issue_valid = 1'b1; a = 64'd99; out_ready = 1'b1;
        cyc();
        issue_valid = 1'b0; out_ready = 1'b0;
        check("credit_ready", 128'(issue_ready), 128'd1);
        check("credit_count", 128'(count), 128'd3);
        drain(40);

        // ---- 6. Reset with results in flight ----
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            issue_valid = 1'b1; a = 64'(31 + c); b = '0;
            cyc();
        end
        issue_valid = 1'b0;
        rst = 1'b1;
        #2 rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            check("flush_valid", 128'(out_valid), 128'd0);
            check("flush_count", 128'(count), 128'd0);
            cyc();
        end

`ifdef ADDRES_STALL_CNT_EN
        // ---- Stall counter: 4 accepts then 5 refused cycles ----
        check("stall_cnt_zero", 128'(stall_cnt), 128'd0);
        out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            issue_valid = 1'b1; a = 64'(50 + c); b = '0;
            cyc();
        end
        issue_valid = 1'b0;
        check("stall_cnt_five", 128'(stall_cnt), 128'd5);
        drain(40);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
